x7seg_scan_multi: RTL and testbench

Parametrised multiplexed 7-segment scan controller: time-multiplexes `NUM_DIGITS` 4-bit digit codes onto one shared BCD/hex data bus and a one-hot active-low anode bus. It adds per-digit enable, leading-zero suppression and a tear-free frame-boundary update handshake. It sits between the classifier result logic and the board's segment decoder/driver.

---
 rtl/x7seg_scan_multi_if.sv | 34 +++
 rtl/x7seg_scan_multi.sv | 115 +++++++++++
 tb/tb_x7seg_scan_multi.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/x7seg_scan_multi_if.sv
// ============================================================================
// Module   : x7seg_scan_multi_if
// Purpose  : Producer-to-scanner update bus for x7seg_scan_multi.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface x7seg_scan_multi_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] digit_data;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_en;
  logic                    upd_valid;
  logic                    upd_ready;

  modport master (
    output digit_data,
    output digit_en,
    output lz_en,
    output upd_valid,
    input  upd_ready
  );

  modport slave (
    input  digit_data,
    input  digit_en,
    input  lz_en,
    input  upd_valid,
    output upd_ready
  );
endinterface

`default_nettype wire

// File: rtl/x7seg_scan_multi.sv
// ============================================================================
// Module   : x7seg_scan_multi
// Purpose  : Multiplexed 7-segment scan with shadowed, frame-boundary update.
//            Define X7SEG_DEADTIME_EN for an all-off window at each slot start.
// Revision : 1.0
// ============================================================================
`default_nettype none

module x7seg_scan_multi #(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_DIV    = 100_000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  x7seg_scan_multi_if.slave     upd,
  output logic [3:0]            x7seg_data,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);

  localparam int c_CNT_W = $clog2(SCAN_DIV);
  localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SCAN_DIV - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 2 || SCAN_DIV < 4 || DEAD_CYCLES >= SCAN_DIV) begin : g_bad_params
    $error("x7seg_scan_multi: illegal parameter combination");
  end

  logic [c_CNT_W-1:0]          r_cnt;
  logic [c_IDX_W-1:0]          r_idx;
  logic [NUM_DIGITS-1:0][3:0]  r_sh_data;
  logic [NUM_DIGITS-1:0]       r_sh_en;
  logic                        r_sh_lz;

  logic                        w_tick;
  logic                        w_boundary;
  logic                        w_xfer;
  logic                        w_dead;
  logic [NUM_DIGITS-1:0]       w_blank;
  logic [NUM_DIGITS-1:0]       w_sel;

  assign w_tick        = (r_cnt == c_CNT_LAST);
  assign w_boundary    = w_tick && (r_idx == c_IDX_LAST);
  assign w_xfer        = w_boundary && upd.upd_valid;
  assign upd.upd_ready = w_boundary;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_sh_data <= '0;
      r_sh_en   <= '0;
      r_sh_lz   <= 1'b0;
    end else begin
      if (w_tick) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Shadow loads only at the wrap, so a frame never mixes old and new data.
      if (w_xfer) begin
        r_sh_data <= upd.digit_data;
        r_sh_en   <= upd.digit_en;
        r_sh_lz   <= upd.lz_en;
      end
    end
  end

  // Walk from the most significant digit down, tracking whether any enabled
  // non-zero digit has been seen yet; until then, suppression blanks digits.
  always_comb begin
    logic v_live_above;
    v_live_above = 1'b0;
    w_blank      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_live_above = v_live_above || (r_sh_en[i] && (r_sh_data[i] != 4'h0));
      w_blank[i]   = !r_sh_en[i] || (r_sh_lz && (i != 0) && !v_live_above);
    end
  end

  always_comb begin
    w_sel        = '0;
    w_sel[r_idx] = 1'b1;
  end

`ifdef X7SEG_DEADTIME_EN
  assign w_dead = (r_cnt < c_CNT_W'(DEAD_CYCLES));
`else
  assign w_dead = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      an         <= '1;
      x7seg_data <= 4'h0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_boundary;
      if (w_blank[r_idx]) begin
        an         <= '1;
        x7seg_data <= 4'h0;
      end else begin
        // Data is already valid during the dead window; only the anode waits.
        an         <= w_dead ? '1 : ~w_sel;
        x7seg_data <= r_sh_data[r_idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_x7seg_scan_multi.sv
// ============================================================================
// Module   : tb_x7seg_scan_multi
// Purpose  : Self-checking bench for x7seg_scan_multi (model + literal pins).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_x7seg_scan_multi;

  localparam int N  = 4;
`ifdef X7SEG_DEADTIME_EN
  localparam int SD = 8;
`else
  localparam int SD = 4;
`endif
  localparam int DC = 2;
  localparam int F  = N * SD;

  logic         sys_clk   = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic [3:0]   x7seg_data;
  logic [N-1:0] an;
  logic         frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  x7seg_scan_multi_if #(.NUM_DIGITS(N)) bus ();

  x7seg_scan_multi #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (SD),
    .DEAD_CYCLES(DC)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .upd       (bus),
    .x7seg_data(x7seg_data),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: blanking decided straight from the rule, digit by digit.
  function automatic bit blank_of(input int i, input logic [4*N-1:0] d,
                                  input logic [N-1:0] en, input logic lz);
    if (!en[i]) return 1'b1;
    if (lz && i != 0) begin
      for (int j = i; j < N; j++)
        if (en[j] && d[4*j +: 4] != 4'h0) return 1'b0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Model state: edges since reset release plus the displayed shadow.
  int               m_k    = 0;
  logic [4*N-1:0]   m_data = '0;
  logic [N-1:0]     m_en   = '0;
  logic             m_lz   = 1'b0;
  logic [N-1:0]     e_an;
  logic [3:0]       e_data;
  logic             e_fd;

  always @(posedge sys_clk) begin
    int slot;
    bit bnd;
    logic [N-1:0] one;
    if (!sys_rst_n) begin
      m_k = 0; m_data = '0; m_en = '0; m_lz = 1'b0;
      e_an = '1; e_data = 4'h0; e_fd = 1'b0;
    end else begin
      slot = (m_k / SD) % N;
      bnd  = (m_k % F) == F - 1;
      one  = 1;
      if (blank_of(slot, m_data, m_en, m_lz)) begin
        e_an = '1; e_data = 4'h0;
      end else begin
        e_data = m_data[4*slot +: 4];
        e_an   = ~(one << slot);
`ifdef X7SEG_DEADTIME_EN
        if ((m_k % SD) < DC) e_an = '1;
`endif
      end
      e_fd = bnd;
      if (bnd && bus.upd_valid) begin
        m_data = bus.digit_data; m_en = bus.digit_en; m_lz = bus.lz_en;
      end
      m_k = m_k + 1;
    end
    #1;
    check("model_an", an, e_an);
    check("model_data", x7seg_data, e_data);
    check("model_frame_done", frame_done, e_fd);
    check("model_upd_ready", bus.upd_ready, sys_rst_n && ((m_k % F) == F - 1));
  end

  logic [N-1:0] cap_an [N];
  logic [3:0]   cap_data [N];
  int           cap_rdy;

  // Starts aligned on a frame_done cycle; ends on the next one.
  task automatic capture_frame(input bit change_mid, input logic [4*N-1:0] mid_data);
    cap_rdy = 0;
    for (int s = 0; s < N; s++) begin
      for (int c = 0; c < SD; c++) begin
        @(posedge sys_clk); #1;
        if (bus.upd_ready) cap_rdy++;
        if (c == SD - 1) begin
          cap_an[s]   = an;
          cap_data[s] = x7seg_data;
        end
        if (change_mid && s == 1 && c == SD / 2) bus.digit_data = mid_data;
      end
    end
    check("frame_done_period", frame_done, 1'b1);
  endtask

  task automatic check_frame(input string nm, input logic [15:0] exp_an, input logic [15:0] exp_data);
    for (int s = 0; s < N; s++) begin
      check({nm, "_an"}, cap_an[s], exp_an[4*s +: 4]);
      check({nm, "_data"}, cap_data[s], exp_data[4*s +: 4]);
    end
  endtask

  // From a reset release: edges until upd_ready first rises and frame_done.
  task automatic measure_first();
    int edges;
    int first_rdy;
    bit found;
    edges = 0; first_rdy = -1; found = 1'b0;
    for (int i = 0; i < 3 * F; i++) begin
      @(posedge sys_clk); #1;
      edges++;
      if (bus.upd_ready && first_rdy < 0) first_rdy = edges;
      if (frame_done) begin
        found = 1'b1;
        break;
      end
    end
    check("first_ready_cycle", first_rdy, F - 1);
    check("first_frame_done_found", found, 1'b1);
    check("first_frame_done_cycle", edges, F);
  endtask

  initial begin
    logic [4*N-1:0] d;
    bus.digit_data = '0;
    bus.digit_en   = '0;
    bus.lz_en      = 1'b0;
    bus.upd_valid  = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_an", an, 4'hF);
    check("reset_data", x7seg_data, 4'h0);
    check("reset_frame_done", frame_done, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    measure_first();
    capture_frame(1'b0, '0);
    check_frame("idle", 16'hFFFF, 16'h0000);

    // Basic scan: transfer at the end of the next frame.
    bus.digit_data = 16'h4321; bus.digit_en = 4'hF; bus.lz_en = 1'b0; bus.upd_valid = 1'b1;
    capture_frame(1'b0, '0);
    check_frame("pre_load", 16'hFFFF, 16'h0000);
    capture_frame(1'b0, '0);
    check_frame("basic", 16'h7BDE, 16'h4321);

    // Mid-frame change must not tear the current frame.
    capture_frame(1'b1, 16'h8765);
    check_frame("upd_hold", 16'h7BDE, 16'h4321);
    check("upd_ready_pulses", cap_rdy, 1);
    capture_frame(1'b0, '0);
    check_frame("upd_new", 16'h7BDE, 16'h8765);

    // Leading-zero suppression.
    bus.digit_data = 16'h0050; bus.lz_en = 1'b1;
    capture_frame(1'b0, '0);
    capture_frame(1'b0, '0);
    check_frame("lz_0050", 16'hFFDE, 16'h0050);
    bus.digit_data = 16'h0000;
    capture_frame(1'b0, '0);
    capture_frame(1'b0, '0);
    check_frame("lz_0000", 16'hFFFE, 16'h0000);

    // Randomised frames, zero-heavy so suppression is exercised.
    for (int it = 0; it < 30; it++) begin
      for (int j = 0; j < N; j++)
        d[4*j +: 4] = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 0));
      bus.digit_data = d;
      bus.digit_en   = N'($urandom);
      bus.lz_en      = 1'($urandom);
      bus.upd_valid  = ($urandom_range(3, 0) != 0);
      capture_frame(1'b0, '0);
    end

    // Enable mask, then reset in the middle of slot 2.
    bus.digit_data = 16'h4321; bus.digit_en = 4'b0101; bus.lz_en = 1'b0; bus.upd_valid = 1'b1;
    capture_frame(1'b0, '0);
    capture_frame(1'b0, '0);
    check_frame("en_mask", 16'hFBFE, 16'h0301);
    bus.upd_valid = 1'b0;
    repeat (2 * SD + 2) @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("async_reset_an", an, 4'hF);
    check("async_reset_data", x7seg_data, 4'h0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    measure_first();
    capture_frame(1'b0, '0);
    check_frame("post_reset", 16'hFFFF, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
